// File: rtl/dmem_resp_model.sv
// dmem_resp_model: data-memory responder standing in for the dcache.
// Accepts one load/store at a time and answers after LATENCY cycles with
// load data / store ack, a nack (replay request) or a misalignment exception.
// Storage is a DEPTH x 64-bit word array; upper address bits alias.
module dmem_resp_model #(
  parameter int ADDR_W     = 40,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 2,
  parameter int NACK_EVERY = 0
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [4:0]        req_cmd_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [2:0]        req_op_type_i,
  input  logic [63:0]       req_data_i,
  input  logic [7:0]        req_tag_i,
  input  logic              req_kill_i,
  output logic              resp_valid_o,
  output logic [63:0]       resp_data_o,
  output logic [7:0]        resp_tag_o,
  output logic              resp_nack_o,
  output logic              xcpt_ma_ld_o,
  output logic              xcpt_ma_st_o
);

  localparam int IDX_W = $clog2(DEPTH);

  // Wait counter: entered with LATENCY-2 so the response is registered
  // in the last wait cycle and pulses exactly LATENCY cycles after accept.
  localparam int              CNT_W    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 2) ? CNT_W'(LATENCY - 2) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Nack counter runs 0..NACK_EVERY-1; the request seen at the last value is nacked.
  localparam int               NACK_W    = (NACK_EVERY > 1) ? $clog2(NACK_EVERY) : 1;
  localparam logic [NACK_W-1:0] NACK_LAST = (NACK_EVERY > 1) ? NACK_W'(NACK_EVERY - 1) : {NACK_W{1'b0}};
  localparam logic [NACK_W-1:0] NACK_ZERO = {NACK_W{1'b0}};
  localparam logic [NACK_W-1:0] NACK_ONE  = NACK_W'(1);
  localparam logic              NACK_EN   = (NACK_EVERY > 0) ? 1'b1 : 1'b0;

  // With LATENCY=1 the response is registered straight from the request inputs.
  localparam logic DIRECT = (LATENCY == 1) ? 1'b1 : 1'b0;

  localparam logic [4:0] CMD_LOAD  = 5'd0;
  localparam logic [4:0] CMD_STORE = 5'd1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // True when the byte offset is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
    logic ma;
    case (size)
      2'd0:    ma = 1'b0;
      2'd1:    ma = off[0];
      2'd2:    ma = |off[1:0];
      2'd3:    ma = |off;
      default: ma = 1'b0;
    endcase
    return ma;
  endfunction

  // Pick the addressed bytes out of a word and sign/zero extend them.
  function automatic logic [63:0] load_extract(input logic [63:0] word, input logic [2:0] off,
                                               input logic [2:0] op);
    logic [63:0] sh;
    logic [63:0] res;
    sh = word >> {off, 3'b000};
    case (op[1:0])
      2'd0:    res = op[2] ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'd1:    res = op[2] ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    res = op[2] ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      2'd3:    res = sh;
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Bit mask covering the 2^size bytes starting at the byte offset.
  function automatic logic [63:0] store_mask(input logic [2:0] off, input logic [1:0] size);
    logic [7:0]  be;
    logic [63:0] m;
    case (size)
      2'd0:    be = 8'h01;
      2'd1:    be = 8'h03;
      2'd2:    be = 8'h0F;
      2'd3:    be = 8'hFF;
      default: be = 8'h00;
    endcase
    be = be << off;
    for (int i = 0; i < 8; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  // Merge right-aligned store data into the old word under the byte mask.
  function automatic logic [63:0] store_merge(input logic [63:0] old, input logic [63:0] data,
                                              input logic [2:0] off, input logic [1:0] size);
    logic [63:0] mask;
    logic [63:0] sh;
    mask = store_mask(off, size);
    sh   = data << {off, 3'b000};
    return (old & ~mask) | (sh & mask);
  endfunction

  // State and pending-request registers
  state_e             state_r;
  state_e             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic               ready_r;
  logic [NACK_W-1:0]  nack_cnt_r;
  logic [4:0]         pend_cmd_r;
  logic [IDX_W-1:0]   pend_idx_r;
  logic [2:0]         pend_off_r;
  logic [2:0]         pend_op_r;
  logic [63:0]        pend_data_r;
  logic [7:0]         pend_tag_r;
  logic               pend_ma_r;
  logic               pend_nack_r;

  // Output registers
  logic               resp_valid_r;
  logic [63:0]        resp_data_r;
  logic [7:0]         resp_tag_r;
  logic               resp_nack_r;
  logic               xcpt_ma_ld_r;
  logic               xcpt_ma_st_r;

  logic [63:0]        mem_r [DEPTH];

  // Request decode
  logic               accept_s;
  logic               in_ldst_s;
  logic               in_ma_s;
  logic               nack_hit_s;
  logic               fire_s;

  // Response source (inputs in IDLE, pending registers in WAIT)
  logic [4:0]         src_cmd_s;
  logic [IDX_W-1:0]   src_idx_s;
  logic [2:0]         src_off_s;
  logic [2:0]         src_op_s;
  logic [63:0]        src_data_s;
  logic [7:0]         src_tag_s;
  logic               src_ma_s;
  logic               src_nack_s;
  logic               src_is_load_s;
  logic               src_is_store_s;

  logic [63:0]        rd_word_s;
  logic [63:0]        wr_word_s;
  logic               wr_en_s;
  logic               nxt_valid_s;
  logic               nxt_nack_s;
  logic               nxt_ma_ld_s;
  logic               nxt_ma_st_s;
  logic [63:0]        nxt_data_s;

  logic               unused_ok_s;

  assign unused_ok_s = ^{1'b0, req_addr_i[ADDR_W-1:3+IDX_W]};

  assign accept_s   = req_valid_i & ready_r & ~req_kill_i;
  assign in_ldst_s  = (req_cmd_i == CMD_LOAD) | (req_cmd_i == CMD_STORE);
  assign in_ma_s    = in_ldst_s & is_misaligned(req_addr_i[2:0], req_op_type_i[1:0]);
  assign nack_hit_s = NACK_EN & ~in_ma_s & (nack_cnt_r == NACK_LAST);

  // Next-state logic and the cycle in which the response gets registered.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    fire_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && DIRECT) begin
          fire_s = 1'b1;
        end else if (accept_s) begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = CNT_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (req_kill_i) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == CNT_ZERO) begin
          fire_s      = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Select where the responding request comes from.
  always_comb begin
    if (state_r == ST_IDLE) begin
      src_cmd_s  = req_cmd_i;
      src_idx_s  = req_addr_i[3 +: IDX_W];
      src_off_s  = req_addr_i[2:0];
      src_op_s   = req_op_type_i;
      src_data_s = req_data_i;
      src_tag_s  = req_tag_i;
      src_ma_s   = in_ma_s;
      src_nack_s = nack_hit_s;
    end else begin
      src_cmd_s  = pend_cmd_r;
      src_idx_s  = pend_idx_r;
      src_off_s  = pend_off_r;
      src_op_s   = pend_op_r;
      src_data_s = pend_data_r;
      src_tag_s  = pend_tag_r;
      src_ma_s   = pend_ma_r;
      src_nack_s = pend_nack_r;
    end
  end

  assign src_is_load_s  = (src_cmd_s == CMD_LOAD);
  assign src_is_store_s = (src_cmd_s == CMD_STORE);
  assign rd_word_s      = mem_r[src_idx_s];
  assign wr_word_s      = store_merge(rd_word_s, src_data_s, src_off_s, src_op_s[1:0]);
  assign wr_en_s        = fire_s & src_is_store_s & ~src_ma_s & ~src_nack_s;

  // Classify the response: exception beats nack beats normal completion.
  always_comb begin
    nxt_valid_s = 1'b0;
    nxt_nack_s  = 1'b0;
    nxt_ma_ld_s = 1'b0;
    nxt_ma_st_s = 1'b0;
    nxt_data_s  = 64'd0;
    if (src_ma_s) begin
      nxt_ma_ld_s = src_is_load_s;
      nxt_ma_st_s = src_is_store_s;
    end else if (src_nack_s) begin
      nxt_nack_s = 1'b1;
    end else begin
      nxt_valid_s = 1'b1;
      if (src_is_load_s) begin
        nxt_data_s = load_extract(rd_word_s, src_off_s, src_op_s);
      end else begin
        nxt_data_s = 64'd0;
      end
    end
  end

  // Control, pending request, nack counter and response registers.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_ZERO;
      ready_r      <= 1'b1;
      nack_cnt_r   <= NACK_ZERO;
      pend_cmd_r   <= 5'd0;
      pend_idx_r   <= {IDX_W{1'b0}};
      pend_off_r   <= 3'd0;
      pend_op_r    <= 3'd0;
      pend_data_r  <= 64'd0;
      pend_tag_r   <= 8'd0;
      pend_ma_r    <= 1'b0;
      pend_nack_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_data_r  <= 64'd0;
      resp_tag_r   <= 8'd0;
      resp_nack_r  <= 1'b0;
      xcpt_ma_ld_r <= 1'b0;
      xcpt_ma_st_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ready_r <= (state_nxt_s == ST_IDLE);
      if (accept_s) begin
        pend_cmd_r  <= req_cmd_i;
        pend_idx_r  <= req_addr_i[3 +: IDX_W];
        pend_off_r  <= req_addr_i[2:0];
        pend_op_r   <= req_op_type_i;
        pend_data_r <= req_data_i;
        pend_tag_r  <= req_tag_i;
        pend_ma_r   <= in_ma_s;
        pend_nack_r <= nack_hit_s;
      end
      if (accept_s && NACK_EN && !in_ma_s) begin
        nack_cnt_r <= nack_hit_s ? NACK_ZERO : (nack_cnt_r + NACK_ONE);
      end
      resp_valid_r <= fire_s & nxt_valid_s;
      resp_nack_r  <= fire_s & nxt_nack_s;
      xcpt_ma_ld_r <= fire_s & nxt_ma_ld_s;
      xcpt_ma_st_r <= fire_s & nxt_ma_st_s;
      if (fire_s) begin
        resp_data_r <= nxt_data_s;
        resp_tag_r  <= src_tag_s;
      end
    end
  end

  // Word array write; shares the edge that registers the response.
  always_ff @(posedge clk_i) begin
    if (rstn_i && wr_en_s) begin
      mem_r[src_idx_s] <= wr_word_s;
    end
  end

  assign req_ready_o  = ready_r;
  assign resp_valid_o = resp_valid_r;
  assign resp_data_o  = resp_data_r;
  assign resp_tag_o   = resp_tag_r;
  assign resp_nack_o  = resp_nack_r;
  assign xcpt_ma_ld_o = xcpt_ma_ld_r;
  assign xcpt_ma_st_o = xcpt_ma_st_r;

endmodule

// File: tb/tb_dmem_resp_model.sv
// Directed bench for dmem_resp_model: three instances
// (LATENCY=2 plain, LATENCY=4 plain, LATENCY=2 with NACK_EVERY=3).
module tb_dmem_resp_model;

  localparam logic [4:0] LD = 5'd0;
  localparam logic [4:0] ST = 5'd1;
  localparam logic [3:0] F_NONE  = 4'b0000;
  localparam logic [3:0] F_VALID = 4'b1000;
  localparam logic [3:0] F_NACK  = 4'b0100;
  localparam logic [3:0] F_MALD  = 4'b0010;
  localparam logic [3:0] F_MAST  = 4'b0001;

  logic        clk;
  logic        rstn  [3];
  logic        valid [3];
  logic [4:0]  cmd   [3];
  logic [39:0] addr  [3];
  logic [2:0]  op    [3];
  logic [63:0] wdata [3];
  logic [7:0]  tag   [3];
  logic        kill  [3];
  logic        ready [3];
  logic        rvalid[3];
  logic [63:0] rdata [3];
  logic [7:0]  rtag  [3];
  logic        rnack [3];
  logic        mald  [3];
  logic        mast  [3];

  int vectors = 0;
  int miscompares = 0;

  dmem_resp_model #(.ADDR_W(40), .DEPTH(256), .LATENCY(2), .NACK_EVERY(0)) u_lat2 (
    .clk_i(clk), .rstn_i(rstn[0]), .req_valid_i(valid[0]), .req_ready_o(ready[0]),
    .req_cmd_i(cmd[0]), .req_addr_i(addr[0]), .req_op_type_i(op[0]), .req_data_i(wdata[0]),
    .req_tag_i(tag[0]), .req_kill_i(kill[0]), .resp_valid_o(rvalid[0]), .resp_data_o(rdata[0]),
    .resp_tag_o(rtag[0]), .resp_nack_o(rnack[0]), .xcpt_ma_ld_o(mald[0]), .xcpt_ma_st_o(mast[0])
  );

  dmem_resp_model #(.ADDR_W(40), .DEPTH(256), .LATENCY(4), .NACK_EVERY(0)) u_lat4 (
    .clk_i(clk), .rstn_i(rstn[1]), .req_valid_i(valid[1]), .req_ready_o(ready[1]),
    .req_cmd_i(cmd[1]), .req_addr_i(addr[1]), .req_op_type_i(op[1]), .req_data_i(wdata[1]),
    .req_tag_i(tag[1]), .req_kill_i(kill[1]), .resp_valid_o(rvalid[1]), .resp_data_o(rdata[1]),
    .resp_tag_o(rtag[1]), .resp_nack_o(rnack[1]), .xcpt_ma_ld_o(mald[1]), .xcpt_ma_st_o(mast[1])
  );

  dmem_resp_model #(.ADDR_W(40), .DEPTH(256), .LATENCY(2), .NACK_EVERY(3)) u_nack3 (
    .clk_i(clk), .rstn_i(rstn[2]), .req_valid_i(valid[2]), .req_ready_o(ready[2]),
    .req_cmd_i(cmd[2]), .req_addr_i(addr[2]), .req_op_type_i(op[2]), .req_data_i(wdata[2]),
    .req_tag_i(tag[2]), .req_kill_i(kill[2]), .resp_valid_o(rvalid[2]), .resp_data_o(rdata[2]),
    .resp_tag_o(rtag[2]), .resp_nack_o(rnack[2]), .xcpt_ma_ld_o(mald[2]), .xcpt_ma_st_o(mast[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%h expected=0x%h", name, obs, exp);
    end
  endtask

  task automatic chk_resp(input int d, input string name, input logic [3:0] flags,
                          input logic [63:0] data, input logic [7:0] t);
    chk({name, "/flags"}, {60'd0, rvalid[d], rnack[d], mald[d], mast[d]}, {60'd0, flags});
    chk({name, "/data"}, rdata[d], data);
    chk({name, "/tag"}, {56'd0, rtag[d]}, {56'd0, t});
  endtask

  task automatic drive(input int d, input logic [4:0] c, input logic [39:0] a,
                       input logic [2:0] o, input logic [63:0] w, input logic [7:0] t);
    valid[d] = 1'b1;
    cmd[d]   = c;
    addr[d]  = a;
    op[d]    = o;
    wdata[d] = w;
    tag[d]   = t;
  endtask

  // Issue one request now and advance to its response cycle.
  task automatic do_req(input int d, input logic [4:0] c, input logic [39:0] a,
                        input logic [2:0] o, input logic [63:0] w, input logic [7:0] t,
                        input int lat);
    drive(d, c, a, o, w, t);
    tick();
    valid[d] = 1'b0;
    repeat (lat - 1) tick();
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rstn[d] = 1'b0; valid[d] = 1'b0; cmd[d] = 5'd0; addr[d] = 40'd0;
      op[d] = 3'd0; wdata[d] = 64'd0; tag[d] = 8'd0; kill[d] = 1'b0;
    end
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      chk_resp(d, "reset", F_NONE, 64'd0, 8'd0);
      chk("reset/ready", {63'd0, ready[d]}, 64'd1);
      rstn[d] = 1'b1;
    end

    // ---------------- LATENCY=2 ----------------
    drive(0, ST, 40'h40, 3'd3, 64'h0123456789ABCDEF, 8'd5);
    tick();
    valid[0] = 1'b0;
    chk("st_d/c1_ready", {63'd0, ready[0]}, 64'd0);
    chk("st_d/c1_pulse", {63'd0, rvalid[0]}, 64'd0);
    tick();
    chk_resp(0, "st_d", F_VALID, 64'd0, 8'd5);
    chk("st_d/c2_ready", {63'd0, ready[0]}, 64'd1);

    do_req(0, LD, 40'h40, 3'd3, 64'd0, 8'd6, 2);
    chk_resp(0, "ld_d", F_VALID, 64'h0123456789ABCDEF, 8'd6);

    do_req(0, ST, 40'h43, 3'd0, 64'h80, 8'd7, 2);
    chk_resp(0, "st_b", F_VALID, 64'd0, 8'd7);
    do_req(0, LD, 40'h43, 3'd0, 64'd0, 8'd8, 2);
    chk_resp(0, "ld_b_s", F_VALID, 64'hFFFFFFFFFFFFFF80, 8'd8);
    do_req(0, LD, 40'h43, 3'd4, 64'd0, 8'd9, 2);
    chk_resp(0, "ld_b_u", F_VALID, 64'h0000000000000080, 8'd9);
    do_req(0, LD, 40'h40, 3'd3, 64'd0, 8'd10, 2);
    chk_resp(0, "ld_d_merged", F_VALID, 64'h0123456780ABCDEF, 8'd10);
    do_req(0, LD, 40'h42, 3'd1, 64'd0, 8'd11, 2);
    chk_resp(0, "ld_h_s", F_VALID, 64'hFFFFFFFFFFFF80AB, 8'd11);
    do_req(0, LD, 40'h44, 3'd6, 64'd0, 8'd12, 2);
    chk_resp(0, "ld_w_u", F_VALID, 64'h0000000001234567, 8'd12);

    do_req(0, LD, 40'h42, 3'd2, 64'd0, 8'd13, 2);
    chk_resp(0, "ma_ld_w", F_MALD, 64'd0, 8'd13);
    do_req(0, ST, 40'h41, 3'd1, 64'hFFFF, 8'd14, 2);
    chk_resp(0, "ma_st_h", F_MAST, 64'd0, 8'd14);
    do_req(0, LD, 40'h40, 3'd3, 64'd0, 8'd15, 2);
    chk_resp(0, "ld_after_ma", F_VALID, 64'h0123456780ABCDEF, 8'd15);

    // store W (upper data bits must be ignored), load accepted in its response cycle
    do_req(0, ST, 40'h48, 3'd2, 64'h12345678DEADBEEF, 8'd16, 2);
    chk_resp(0, "st_w", F_VALID, 64'd0, 8'd16);
    do_req(0, LD, 40'h48, 3'd6, 64'd0, 8'd17, 2);
    chk_resp(0, "ld_w_b2b", F_VALID, 64'h00000000DEADBEEF, 8'd17);

    do_req(0, 5'd2, 40'h40, 3'd3, 64'h5A5A, 8'd18, 2);
    chk_resp(0, "noop", F_VALID, 64'd0, 8'd18);

    // reset in c+1 of a store
    drive(0, ST, 40'h40, 3'd3, 64'h1111111111111111, 8'd19);
    tick();
    valid[0] = 1'b0;
    rstn[0]  = 1'b0;
    tick();
    chk_resp(0, "rst_mid", F_NONE, 64'd0, 8'd0);
    chk("rst_mid/ready", {63'd0, ready[0]}, 64'd1);
    rstn[0] = 1'b1;
    do_req(0, LD, 40'h40, 3'd3, 64'd0, 8'd20, 2);
    chk_resp(0, "ld_after_rst", F_VALID, 64'h0123456780ABCDEF, 8'd20);

    // ---------------- LATENCY=4 ----------------
    do_req(1, ST, 40'h80, 3'd3, 64'hAAAABBBBCCCCDDDD, 8'd1, 4);
    chk_resp(1, "l4_st", F_VALID, 64'd0, 8'd1);

    drive(1, LD, 40'h80, 3'd3, 64'd0, 8'd2);
    tick();
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("l4_hold/c%0d_ready", k), {63'd0, ready[1]}, 64'd0);
      chk($sformatf("l4_hold/c%0d_pulse", k), {60'd0, rvalid[1], rnack[1], mald[1], mast[1]}, 64'd0);
      tick();
    end
    valid[1] = 1'b0;
    chk_resp(1, "l4_ld", F_VALID, 64'hAAAABBBBCCCCDDDD, 8'd2);
    chk("l4_ld/ready", {63'd0, ready[1]}, 64'd1);

    drive(1, ST, 40'h80, 3'd3, 64'h5555555555555555, 8'd3);
    tick();
    valid[1] = 1'b0;
    tick();
    kill[1] = 1'b1;
    chk("l4_kill/c2_ready", {63'd0, ready[1]}, 64'd0);
    tick();
    kill[1] = 1'b0;
    chk("l4_kill/c3_ready", {63'd0, ready[1]}, 64'd1);
    chk("l4_kill/c3_pulse", {60'd0, rvalid[1], rnack[1], mald[1], mast[1]}, 64'd0);
    tick();
    chk("l4_kill/c4_pulse", {60'd0, rvalid[1], rnack[1], mald[1], mast[1]}, 64'd0);
    do_req(1, LD, 40'h80, 3'd3, 64'd0, 8'd4, 4);
    chk_resp(1, "l4_ld_after_kill", F_VALID, 64'hAAAABBBBCCCCDDDD, 8'd4);

    // ---------------- NACK_EVERY=3 ----------------
    do_req(2, ST, 40'h00, 3'd3, 64'hA0, 8'd1, 2);
    chk_resp(2, "nk_st1", F_VALID, 64'd0, 8'd1);
    do_req(2, ST, 40'h08, 3'd3, 64'hB1, 8'd2, 2);
    chk_resp(2, "nk_st2", F_VALID, 64'd0, 8'd2);
    do_req(2, ST, 40'h10, 3'd3, 64'hC2, 8'd3, 2);
    chk_resp(2, "nk_st3", F_NACK, 64'd0, 8'd3);
    do_req(2, ST, 40'h10, 3'd3, 64'hC2, 8'd4, 2);
    chk_resp(2, "nk_st3_replay", F_VALID, 64'd0, 8'd4);
    rstn[2] = 1'b0;
    tick();
    rstn[2] = 1'b1;
    do_req(2, LD, 40'h00, 3'd3, 64'd0, 8'd10, 2);
    chk_resp(2, "nk_ld1", F_VALID, 64'hA0, 8'd10);
    do_req(2, LD, 40'h08, 3'd3, 64'd0, 8'd11, 2);
    chk_resp(2, "nk_ld2", F_VALID, 64'hB1, 8'd11);
    do_req(2, LD, 40'h10, 3'd3, 64'd0, 8'd12, 2);
    chk_resp(2, "nk_ld3", F_NACK, 64'd0, 8'd12);
    do_req(2, LD, 40'h00, 3'd3, 64'd0, 8'd13, 2);
    chk_resp(2, "nk_ld4", F_VALID, 64'hA0, 8'd13);
    do_req(2, LD, 40'h08, 3'd3, 64'd0, 8'd14, 2);
    chk_resp(2, "nk_ld5", F_VALID, 64'hB1, 8'd14);
    do_req(2, LD, 40'h10, 3'd3, 64'd0, 8'd15, 2);
    chk_resp(2, "nk_ld6", F_NACK, 64'd0, 8'd15);
    do_req(2, LD, 40'h10, 3'd3, 64'd0, 8'd16, 2);
    chk_resp(2, "nk_ld3_replay", F_VALID, 64'hC2, 8'd16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
